seg7_scan_capture: RTL and testbench

- Receive-side counterpart of the BCD-to-7-segment decoder. Samples a time-multiplexed 4-digit 7-segment bus (segments plus digit anodes) and decodes each segment pattern back to BCD.
- Filters transition glitches with a stability counter and assembles complete 4-digit frames.
- Delivers each frame over a valid/ready handshake.
- Used as a loopback checker behind the display-driver path and as a capture front-end in lab benches.

---
 rtl/seg7_scan_capture.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_capture.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed 4-digit 7-segment bus, filters glitches, decodes each digit back to BCD
// and delivers complete frames over valid/ready. Define SEG7_HEX_EN to accept hex glyphs A..F.
module seg7_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] out_bcd,
  output logic [3:0]  out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [10:0]   prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [3:0]    mask_q, mask_d;
  logic [15:0]   stage_bcd_q, stage_bcd_d;
  logic [3:0]    stage_err_q, stage_err_d;
  logic [15:0]   out_bcd_q, out_bcd_d;
  logic [3:0]    out_err_q, out_err_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;

  logic       one_hot, same, capture, frame_done;
  logic [1:0] idx;
  logic [4:0] dec;  // {err, digit}

  // Returns {err, digit}; unknown patterns map to 4'hF with err set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h7E: decode = 5'h00;
      7'h30: decode = 5'h01;
      7'h6D: decode = 5'h02;
      7'h79: decode = 5'h03;
      7'h33: decode = 5'h04;
      7'h5B: decode = 5'h05;
      7'h5F: decode = 5'h06;
      7'h70: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h7B: decode = 5'h09;
`ifdef SEG7_HEX_EN
      7'h77: decode = 5'h0A;
      7'h1F: decode = 5'h0B;
      7'h4E: decode = 5'h0C;
      7'h3D: decode = 5'h0D;
      7'h4F: decode = 5'h0E;
      7'h47: decode = 5'h0F;
`endif
      default: decode = 5'h1F;
    endcase
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    idx = 2'd0;
    case (an)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase

    one_hot = (an != 4'b0000) && ((an & (an - 4'd1)) == 4'b0000);
    same    = ({an, seg} == prev_q);
    dec     = decode(seg);

    if (!one_hot)           cnt_d = '0;
    else if (!same)         cnt_d = CW'(1);
    else if (cnt_q < CNT_MAX) cnt_d = cnt_q + CW'(1);
    else                    cnt_d = cnt_q;

    // A changed sample re-arms in the same cycle, which matters when STABLE_CYCLES is 1.
    capture = one_hot && (armed_q || !same) && (cnt_d == CNT_MAX);

    if (capture)                armed_d = 1'b0;
    else if (!one_hot || !same) armed_d = 1'b1;
    else                        armed_d = armed_q;

    stage_bcd_d = stage_bcd_q;
    stage_err_d = stage_err_q;
    mask_d      = mask_q;
    out_bcd_d   = out_bcd_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    frame_done  = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (capture) begin
      stage_bcd_d[4*idx +: 4] = dec[3:0];
      stage_err_d[idx]        = dec[4];
      frame_done              = ((mask_q | an) == 4'hF);
      mask_d                  = frame_done ? 4'h0 : (mask_q | an);
    end

    if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_bcd_d   = stage_bcd_d;
        out_err_d   = stage_err_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous.
    if (!rst_n) begin
      prev_q      <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b1;
      mask_q      <= '0;
      stage_bcd_q <= '0;
      stage_err_q <= '0;
      out_bcd_q   <= '0;
      out_err_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      prev_q      <= {an, seg};
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      mask_q      <= mask_d;
      stage_bcd_q <= stage_bcd_d;
      stage_err_q <= stage_err_d;
      out_bcd_q   <= out_bcd_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_bcd   = out_bcd_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: stimulus pushes expected frames, a monitor pops them
// on each handshake. Expectations for hex glyphs follow SEG7_HEX_EN.
module tb_seg7_scan_capture;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  err;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] out_bcd;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  frame_t exp_q[$];

  seg7_scan_capture #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .an        (an),
    .out_bcd   (out_bcd),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold one digit for n sampling edges; returns at #1 after the last edge.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    drive(4'b0001, s0, 4);
    drive(4'b0010, s1, 4);
    drive(4'b0100, s2, 4);
    drive(4'b1000, s3, 4);
  endtask

  task automatic push(input logic [15:0] b, input logic [3:0] e);
    frame_t f;
    f.bcd = b;
    f.err = e;
    exp_q.push_back(f);
  endtask

  // Monitor: every handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got bcd=%h err=%b with nothing expected", out_bcd, out_err);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        check("frame_bcd", 32'(out_bcd), 32'(e.bcd));
        check("frame_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    an = 4'b0000;
    seg = 7'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_bcd", 32'(out_bcd), 0);
    check("rst_err", 32'(out_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;

    // Basic scan 1235; out_valid must be high right after the last capture edge.
    push(16'h1235, 4'h0);
    scan4(7'h5B, 7'h79, 7'h6D, 7'h30);
    check("latency_valid", 32'(out_valid), 1);
    drive(4'b0000, 7'h00, 2);
    check("valid_drop", 32'(out_valid), 0);

    // Glitch filter: 7E for only 3 cycles never captures; 7F wins.
    push(16'h1238, 4'h0);
    drive(4'b0001, 7'h7E, 3);
    drive(4'b0001, 7'h7F, 4);
    drive(4'b0010, 7'h79, 4);
    drive(4'b0100, 7'h6D, 4);
    drive(4'b1000, 7'h30, 4);
    drive(4'b0000, 7'h00, 2);

    // Illegal pattern on digit 2, then a non-one-hot select that must not capture.
    push(16'h1F35, 4'b0100);
    drive(4'b0001, 7'h5B, 4);
    drive(4'b0010, 7'h79, 4);
    drive(4'b0100, 7'h00, 4);
    drive(4'b0011, 7'h30, 10);
    check("nonhot_no_frame", 32'(out_valid), 0);
    drive(4'b1000, 7'h30, 4);
    drive(4'b0000, 7'h00, 2);

    // Back-pressure: second frame is dropped, first one held stable.
    out_ready = 1'b0;
    push(16'h1235, 4'h0);
    scan4(7'h5B, 7'h79, 7'h6D, 7'h30);
    check("bp_valid", 32'(out_valid), 1);
    scan4(7'h5F, 7'h70, 7'h7F, 7'h7B);
    check("bp_overrun", 32'(overrun), 1);
    check("bp_bcd_hold", 32'(out_bcd), 32'h1235);
    check("bp_valid_hold", 32'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_after", 32'(out_valid), 0);
    check("overrun_sticky", 32'(overrun), 1);

    // Reset mid-frame drops the partial frame and clears overrun.
    drive(4'b0001, 7'h5B, 4);
    drive(4'b0010, 7'h79, 4);
    rst_n = 1'b0;
    an = 4'b0000;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_bcd", 32'(out_bcd), 0);
    check("mid_rst_err", 32'(out_err), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    push(16'h0000, 4'h0);
    scan4(7'h7E, 7'h7E, 7'h7E, 7'h7E);
    drive(4'b0000, 7'h00, 2);

    // Hex glyph A on digit 3.
`ifdef SEG7_HEX_EN
    push(16'hA000, 4'b0000);
`else
    push(16'hF000, 4'b1000);
`endif
    scan4(7'h7E, 7'h7E, 7'h7E, 7'h77);
    drive(4'b0000, 7'h00, 2);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
